fp_align_add: RTL

- Upstream neighbour of the normalize stage in the single-precision FP adder.
- Accepts two IEEE-754 binary32 operands through a valid/ready handshake, unpacks them, and orders them by magnitude.
- Aligns the smaller mantissa with a multi-cycle right shifter that collects guard, round and sticky bits, then adds or subtracts.
- Presents {alignedResult, guardBit, roundBit, stickyBit, exponentOut, alignedSign} to the normalize stage, with any carry already folded back so only left-normalization remains downstream.

---
 rtl/fp_pkg.sv | 12 +
 rtl/fp_align_add_if.sv | 26 ++
 rtl/fp_sticky_shift.sv | 17 +
 rtl/fp_align_add.sv | 109 ++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared types and constants for the FP align/add stage.
package fp_pkg;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;
    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_ADD, S_DONE} align_state_t;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;
    localparam logic [23:0] QNAN_MANT = 24'hC00000;
    localparam int          EXT_W     = 27;
endpackage

// File: rtl/fp_align_add_if.sv
// fp_align_add_if: operand/result handshake bundle between the aligner and its neighbours.
interface fp_align_add_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] alignedResult;
    logic        guardBit;
    logic        roundBit;
    logic        stickyBit;
    logic [7:0]  exponentOut;
    logic        alignedSign;
    logic        special;
    modport master (
        output in_valid, opA, opB, out_ready,
        input  in_ready, out_valid, alignedResult, guardBit, roundBit, stickyBit,
               exponentOut, alignedSign, special
    );
    modport slave (
        input  in_valid, opA, opB, out_ready,
        output in_ready, out_valid, alignedResult, guardBit, roundBit, stickyBit,
               exponentOut, alignedSign, special
    );
endinterface

// File: rtl/fp_sticky_shift.sv
// fp_sticky_shift: right shift by min(rem_i, SHIFT_STEP), OR-ing shifted-out bits into bit 0.
module fp_sticky_shift import fp_pkg::*; #(
    parameter int SHIFT_STEP = 4
) (
    input  logic [EXT_W-1:0] x_i,
    input  logic [4:0]       rem_i,
    output logic [EXT_W-1:0] y_o,
    output logic [4:0]       sh_o
);
    logic [EXT_W-1:0] mask, shifted;
    always_comb begin
        sh_o    = (rem_i > 5'(SHIFT_STEP)) ? 5'(SHIFT_STEP) : rem_i;
        mask    = ~({EXT_W{1'b1}} << sh_o);
        shifted = x_i >> sh_o;
        y_o     = {shifted[EXT_W-1:1], shifted[0] | (|(x_i & mask))};
    end
endmodule

// File: rtl/fp_align_add.sv
// fp_align_add: unpack, order, align and add two binary32 operands for the normalize stage.
module fp_align_add import fp_pkg::*; #(
    parameter int SHIFT_STEP = 4
) (
    input logic          clk,
    input logic          rst,
    fp_align_add_if.slave io
);
    align_state_t     state_q, state_d;
    fp32_t            a, b;
    logic             a_nan, b_nan, a_inf, b_inf, a_big, nan_res;
    logic [7:0]       ea, eb, diff;
    logic [23:0]      ma, mb;
    logic [EXT_W-1:0] x_q, x_d, x_sh;
    logic [4:0]       rem_q, rem_d, sh;
    logic [23:0]      mant_q, mant_d, res_q, res_d;
    logic [7:0]       exp_q, exp_d, eo_q, eo_d;
    logic             sign_q, sign_d, sub_q, sub_d, spec_q, spec_d;
    logic             g_q, g_d, r_q, r_d, s_q, s_d, so_q, so_d, sp_q, sp_d;
    logic [27:0]      sum;
    assign a       = io.opA;
    assign b       = io.opB;
    assign a_nan   = (&a.exp) & (|a.frac);
    assign b_nan   = (&b.exp) & (|b.frac);
    assign a_inf   = (&a.exp) & ~(|a.frac);
    assign b_inf   = (&b.exp) & ~(|b.frac);
    assign nan_res = a_nan | b_nan | (a_inf & b_inf & (a.sign ^ b.sign));
    assign ea      = (a.exp == 8'd0) ? 8'd1 : a.exp;
    assign eb      = (b.exp == 8'd0) ? 8'd1 : b.exp;
    assign ma      = {|a.exp, a.frac};
    assign mb      = {|b.exp, b.frac};
    assign a_big   = {ea, ma} >= {eb, mb};
    assign diff    = a_big ? ea - eb : eb - ea;
    // Big magnitude always dominates the aligned small one, so subtraction never borrows.
    assign sum     = sub_q ? {1'b0, mant_q, 3'b000} - {1'b0, x_q}
                           : {1'b0, mant_q, 3'b000} + {1'b0, x_q};
    fp_sticky_shift #(.SHIFT_STEP(SHIFT_STEP)) u_shift (
        .x_i(x_q), .rem_i(rem_q), .y_o(x_sh), .sh_o(sh)
    );
    always_comb begin
        state_d = state_q;
        x_d = x_q; rem_d = rem_q; mant_d = mant_q; exp_d = exp_q;
        sign_d = sign_q; sub_d = sub_q; spec_d = spec_q;
        res_d = res_q; g_d = g_q; r_d = r_q; s_d = s_q;
        eo_d = eo_q; so_d = so_q; sp_d = sp_q;
        unique case (state_q)
            S_IDLE: if (io.in_valid) begin
                spec_d  = a_nan | b_nan | a_inf | b_inf;
                sub_d   = a.sign ^ b.sign;
                exp_d   = a_big ? ea : eb;
                x_d     = {(a_big ? mb : ma), 3'b000};
                rem_d   = (diff > 8'd27) ? 5'd27 : diff[4:0];
                mant_d  = nan_res ? QNAN_MANT : (a_inf | b_inf) ? 24'h800000 : (a_big ? ma : mb);
                sign_d  = nan_res ? 1'b0 : a_inf ? a.sign : b_inf ? b.sign : (a_big ? a.sign : b.sign);
                state_d = (spec_d || rem_d == 5'd0) ? S_ADD : S_ALIGN;
            end
            S_ALIGN: begin
                x_d     = x_sh;
                rem_d   = rem_q - sh;
                state_d = (rem_d == 5'd0) ? S_ADD : S_ALIGN;
            end
            S_ADD: begin
                state_d = S_DONE;
                {g_d, r_d, s_d} = 3'b000;
                so_d = sign_q;
                sp_d = 1'b0;
                if (spec_q) begin
                    res_d = mant_q; eo_d = EXP_MAX; sp_d = 1'b1;
                end else if (sum == 28'd0) begin
                    res_d = 24'd0; eo_d = 8'd0; so_d = 1'b0;
                end else if (sum[27] && exp_q == 8'd254) begin
                    res_d = 24'h800000; eo_d = EXP_MAX; sp_d = 1'b1;
                end else if (sum[27]) begin
                    res_d = sum[27:4]; g_d = sum[3]; r_d = sum[2]; s_d = sum[1] | sum[0];
                    eo_d  = exp_q + 8'd1;
                end else begin
                    res_d = sum[26:3]; g_d = sum[2]; r_d = sum[1]; s_d = sum[0];
                    eo_d  = exp_q;
                end
            end
            S_DONE: if (io.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q <= '0; rem_q <= '0; mant_q <= '0; exp_q <= '0;
            sign_q <= 1'b0; sub_q <= 1'b0; spec_q <= 1'b0;
            res_q <= '0; g_q <= 1'b0; r_q <= 1'b0; s_q <= 1'b0;
            eo_q <= '0; so_q <= 1'b0; sp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q <= x_d; rem_q <= rem_d; mant_q <= mant_d; exp_q <= exp_d;
            sign_q <= sign_d; sub_q <= sub_d; spec_q <= spec_d;
            res_q <= res_d; g_q <= g_d; r_q <= r_d; s_q <= s_d;
            eo_q <= eo_d; so_q <= so_d; sp_q <= sp_d;
        end
    end
    assign io.in_ready      = (state_q == S_IDLE);
    assign io.out_valid     = (state_q == S_DONE);
    assign io.alignedResult = res_q;
    assign io.guardBit      = g_q;
    assign io.roundBit      = r_q;
    assign io.stickyBit     = s_q;
    assign io.exponentOut   = eo_q;
    assign io.alignedSign   = so_q;
    assign io.special       = sp_q;
endmodule
